// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    // Width of one lookahead group.
    localparam int GRP_W = 4;

    // Carry-in forced when subtracting (two's complement: a + ~b + 1).
    localparam logic SUB_CIN = 1'b1;

    // Number of lookahead groups needed to cover a given operand width.
    function automatic int grp_count(input int width);
        return (width + GRP_W - 1) / GRP_W;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group: internal carries c1..c3 plus the
// group generate/propagate terms used by the second lookahead level.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             cin,
    output logic [GRP_W-1:1] c,
    output logic             g_grp,
    output logic             p_grp
);

    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;

    // Per-bit terms and fully flattened in-group lookahead equations.
    always_comb begin
        g     = a & b;
        p     = a | b;
        c[1]  = g[0] | (p[0] & cin);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
        g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        p_grp = &p;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes on both sides. Stage 1 registers operands and group G/P;
// stage 2 resolves group carries by lookahead and registers the result.
// Optional macro CLA_PIPE_FLAGS_EN adds registered ovf and zero outputs.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int NGRP = grp_count(WIDTH);

    logic                  s1_valid;
    logic                  in_xfer;
    logic                  adv2;

    // Stage-1 inputs (combinational) and registers.
    logic [WIDTH-1:0]      bx_p0;
    logic                  c0_p0;
    logic [NGRP-1:0]       g_p0;
    logic [NGRP-1:0]       p_p0;
    logic [WIDTH-1:0]      a_p1;
    logic [WIDTH-1:0]      bx_p1;
    logic                  c0_p1;
    logic [NGRP-1:0]       g_p1;
    logic [NGRP-1:0]       p_p1;

    // Stage-2 carry network and result.
    logic [NGRP:0]         gc_p1;
    logic [3*NGRP-1:0]     in_c_p1;
    logic [WIDTH-1:0]      cbit_p1;
    logic [WIDTH-1:0]      sum_p1;
    logic                  term;
    logic                  acc;

    // Stage-1 group instances only need G/P; stage-2 instances only carries.
    logic [3*NGRP-1:0]     unused_c_p0;
    logic [NGRP-1:0]       unused_g_p1;
    logic [NGRP-1:0]       unused_p_p1;

    assign in_xfer  = in_valid & in_ready;
    assign adv2     = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | adv2;

    // Operand conditioning: subtract inverts B and forces the carry-in.
    always_comb begin
        bx_p0 = b ^ {WIDTH{sub}};
        c0_p0 = sub ? SUB_CIN : ci;
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla_group4 u_gp (
            .a     (a[GRP_W*k +: GRP_W]),
            .b     (bx_p0[GRP_W*k +: GRP_W]),
            .cin   (1'b0),
            .c     (unused_c_p0[3*k +: 3]),
            .g_grp (g_p0[k]),
            .p_grp (p_p0[k])
        );

        cla_group4 u_cy (
            .a     (a_p1[GRP_W*k +: GRP_W]),
            .b     (bx_p1[GRP_W*k +: GRP_W]),
            .cin   (gc_p1[k]),
            .c     (in_c_p1[3*k +: 3]),
            .g_grp (unused_g_p1[k]),
            .p_grp (unused_p_p1[k])
        );

        assign cbit_p1[GRP_W*k]                 = gc_p1[k];
        assign cbit_p1[GRP_W*k+1 +: GRP_W-1]    = in_c_p1[3*k +: 3];
    end

    // Second-level lookahead: each group carry is a flat sum of products of
    // the stage-1 G/P terms and c0, so no carry ripples between groups.
    always_comb begin
        gc_p1    = '0;
        term     = 1'b0;
        acc      = 1'b0;
        gc_p1[0] = c0_p1;
        for (int k = 0; k < NGRP; k++) begin
            term = c0_p1;
            for (int m = 0; m <= k; m++) term = term & p_p1[m];
            acc = term;
            for (int j = 0; j <= k; j++) begin
                term = g_p1[j];
                for (int m = j + 1; m <= k; m++) term = term & p_p1[m];
                acc = acc | term;
            end
            gc_p1[k+1] = acc;
        end
    end

    assign sum_p1 = a_p1 ^ bx_p1 ^ cbit_p1;

    // ---- stage 0 -> stage 1 boundary ----
    // Pipeline occupancy: stage-1 holding flag and output valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (in_xfer)   s1_valid <= 1'b1;
            else if (adv2) s1_valid <= 1'b0;
            if (adv2)           out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
        end
    end

    // Stage-1 capture of conditioned operands and group G/P on input transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_p1  <= '0;
            bx_p1 <= '0;
            c0_p1 <= 1'b0;
            g_p1  <= '0;
            p_p1  <= '0;
        end else if (in_xfer) begin
            a_p1  <= a;
            bx_p1 <= bx_p0;
            c0_p1 <= c0_p0;
            g_p1  <= g_p0;
            p_p1  <= p_p0;
        end
    end

    // ---- stage 1 -> stage 2 boundary ----
    // Result register; holds during output stall because adv2 stays low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s    <= '0;
            co   <= 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
            ovf  <= 1'b0;
            zero <= 1'b0;
`endif
        end else if (adv2) begin
            s    <= sum_p1;
            co   <= gc_p1[NGRP];
`ifdef CLA_PIPE_FLAGS_EN
            ovf  <= cbit_p1[WIDTH-1] ^ gc_p1[NGRP];
            zero <= ~|sum_p1;
`endif
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=32) with a behavioural
// scoreboard model and directed literal cases.
module tb_cla_pipe_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
`ifdef CLA_PIPE_FLAGS_EN
    logic         ovf;
    logic         zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t         mq[$];
    int           in_cyc_log[$];
    int           out_cyc_log[$];
    logic [W-1:0] out_log[$];

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
`ifdef CLA_PIPE_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain wide arithmetic; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                   input logic ci_i, input logic sub_i);
        logic [W-1:0] bop;
        logic [W:0]   full;
        exp_t         e;
        bop    = sub_i ? ~b_i : b_i;
        full   = {1'b0, a_i} + {1'b0, bop} + {{W{1'b0}}, (sub_i ? 1'b1 : ci_i)};
        e.s    = full[W-1:0];
        e.co   = full[W];
        e.ovf  = (a_i[W-1] == bop[W-1]) && (e.s[W-1] != a_i[W-1]);
        e.zero = (e.s == '0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard / monitor, sampling on the falling edge.
    initial begin : monitor
        logic         stall_prev;
        logic [W-1:0] s_prev;
        logic         co_prev;
        exp_t         e;
        stall_prev = 1'b0;
        s_prev     = '0;
        co_prev    = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mq.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_hold_valid", 64'(out_valid), 64'(1));
                    chk("stall_hold_s", 64'(s), 64'(s_prev));
                    chk("stall_hold_co", 64'(co), 64'(co_prev));
                end
                if (out_valid && out_ready) begin
                    if (mq.size() == 0) begin
                        chk("spurious_out", 64'(out_valid), 64'(0));
                    end else begin
                        e = mq.pop_front();
                        chk("sb_s", 64'(s), 64'(e.s));
                        chk("sb_co", 64'(co), 64'(e.co));
`ifdef CLA_PIPE_FLAGS_EN
                        chk("sb_ovf", 64'(ovf), 64'(e.ovf));
                        chk("sb_zero", 64'(zero), 64'(e.zero));
`endif
                        out_log.push_back(s);
                        out_cyc_log.push_back(cyc);
                    end
                end
                if (in_valid && in_ready) begin
                    mq.push_back(model(a, b, ci, sub));
                    in_cyc_log.push_back(cyc);
                end
                stall_prev = out_valid && !out_ready;
                s_prev     = s;
                co_prev    = co;
            end
        end
    end

    // Present one bundle from posedge+1 until accepted; scramble operands after.
    task automatic send(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic ci_i, input logic sub_i);
        int   t;
        logic acc;
        t        = 0;
        a        = a_i;
        b        = b_i;
        ci       = ci_i;
        sub      = sub_i;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 50) begin
                chk("send_timeout", 64'(in_ready), 64'(1));
                break;
            end
        end
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        ci       = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((mq.size() != 0 || out_valid) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_drain"}, 64'(mq.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Single directed operation with literal expectations and latency check.
    task automatic run_one(input string nm, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                           input logic ci_i, input logic sub_i, input logic [W-1:0] es,
                           input logic eco, input logic eovf, input logic ezero);
        exp_t m;
        m = model(a_i, b_i, ci_i, sub_i);
        chk({nm, "_model_s"}, 64'(m.s), 64'(es));
        chk({nm, "_model_co"}, 64'(m.co), 64'(eco));
        chk({nm, "_model_ovf"}, 64'(m.ovf), 64'(eovf));
        chk({nm, "_model_zero"}, 64'(m.zero), 64'(ezero));
        out_ready = 1'b1;
        send(a_i, b_i, ci_i, sub_i);
        @(negedge clk);
        chk({nm, "_valid_c1"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        chk({nm, "_valid_c2"}, 64'(out_valid), 64'(1));
        chk({nm, "_s"}, 64'(s), 64'(es));
        chk({nm, "_co"}, 64'(co), 64'(eco));
`ifdef CLA_PIPE_FLAGS_EN
        chk({nm, "_ovf"}, 64'(ovf), 64'(eovf));
        chk({nm, "_zero"}, 64'(zero), 64'(ezero));
`endif
        @(negedge clk);
        chk({nm, "_valid_once"}, 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   base_in;
        int   base_out;
        int   base_acc;
        logic rb_done;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        rb_done   = 1'b0;

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_s", 64'(s), 64'(0));
        chk("rst_co", 64'(co), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef CLA_PIPE_FLAGS_EN
        chk("rst_ovf", 64'(ovf), 64'(0));
        chk("rst_zero", 64'(zero), 64'(0));
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_one("add",         32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0009, 1'b0, 1'b0, 1'b0);
        run_one("carry_chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("sub_borrow",  32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_one("sub_ci_ign",  32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        run_one("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        // Backpressure: four back-to-back bundles, consumer stalled 5 cycles.
        base_acc  = in_cyc_log.size();
        base_out  = out_log.size();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(W'(i), W'(i), 1'b0, 1'b0);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", 64'(in_ready), 64'(0));
                    chk("bp_s_hold", 64'(s), 64'(2));
                    chk("bp_out_valid", 64'(out_valid), 64'(1));
                end
                chk("bp_accepted", 64'(in_cyc_log.size() - base_acc), 64'(2));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp");
        chk("bp_count", 64'(out_log.size() - base_out), 64'(4));
        if (out_log.size() - base_out == 4) begin
            for (int i = 0; i < 4; i++)
                chk("bp_order", 64'(out_log[base_out + i]), 64'(2 * (i + 1)));
        end

        // Full throughput: 100 random bundles with the consumer always ready.
        out_ready = 1'b1;
        base_in   = in_cyc_log.size();
        base_out  = out_cyc_log.size();
        for (int i = 0; i < 100; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain("tp");
        chk("tp_count", 64'(out_cyc_log.size() - base_out), 64'(100));
        if (out_cyc_log.size() - base_out == 100 && in_cyc_log.size() - base_in == 100) begin
            chk("tp_in_span", 64'(in_cyc_log[base_in + 99] - in_cyc_log[base_in]), 64'(99));
            chk("tp_out_span", 64'(out_cyc_log[base_out + 99] - out_cyc_log[base_out]), 64'(99));
            chk("tp_latency", 64'(out_cyc_log[base_out] - in_cyc_log[base_in]), 64'(2));
        end

        // Random backpressure with random bundles.
        fork
            begin
                for (int i = 0; i < 60; i++)
                    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                rb_done = 1'b1;
            end
            begin
                while (!rb_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain("rb");

        // Reset with two bundles in flight.
        out_ready = 1'b0;
        send(32'h0000_0007, 32'h0000_0008, 1'b0, 1'b0);
        send(32'h0000_0009, 32'h0000_0009, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        chk("mrst_s", 64'(s), 64'(0));
        chk("mrst_co", 64'(co), 64'(0));
        chk("mrst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mrst_no_stale", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        run_one("post_reset", 32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0, 32'h0000_2345, 1'b0, 1'b0, 1'b0);
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, with a second level of group lookahead across groups.
- Two register stages with a valid/ready handshake on both sides.
- Full throughput: one operation per cycle, 2-cycle latency.
- Sits in the datapath wherever registered WIDTH-bit add/sub results are needed under backpressure.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 4 and at least 4.
- NGRP, WIDTH/4, number of 4-bit lookahead groups; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  adder can accept a bundle this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in; ignored when sub=1
- sub  input  1  0 = add, 1 = subtract (A−B)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum/difference
- co  output  1  carry out of the MSB; for subtract, 1 = no borrow

Behaviour:
- Reset (async, active-high): s1_valid=0, out_valid=0, s=0, co=0, all stage-1 data registers 0. in_ready=1 after reset. Reset mid-operation discards all in-flight bundles.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Stage 1 captures on input transfer:
  - bx = b XOR {WIDTH{sub}}, and A.
  - c0 = sub ? 1 : ci.
  - Per-bit g = a & bx, p = a | bx.
  - Per-group G/P: G = g3 | p3g2 | p3p2g1 | p3p2p1g0; P = p3p2p1p0.
- Stage 2 advance: adv2 = s1_valid & (~out_valid | out_ready).
  - On adv2: compute group carries C[k+1] = G[k] | P[k]&C[k] with C[0]=c0, flattened as lookahead (no ripple across groups).
  - Compute in-group carries, then s = a ^ bx ^ carries and co = C[NGRP]; register s, co; set out_valid=1.
- out_valid clears on output transfer with no adv2 in the same cycle.
- in_ready = ~s1_valid | adv2 (combinational).
- s1_valid: set on input transfer; cleared on adv2 without a simultaneous input transfer.
- Latency: result visible 2 clocks after input transfer when out_ready=1.
- Stall: while out_valid & ~out_ready, s and co hold stable; stage 1 holds one bundle; in_ready drops once stage 1 is full.
- Simultaneous output transfer, adv2 and input transfer in one cycle: all three occur; no bubble, no loss.
- Arithmetic is mod 2^WIDTH:
  - Add: {co,s} = a + b + ci.
  - Subtract: {co,s} = a + ~b + 1.
- Operands a, b, ci, sub are sampled only on input transfer; changes at other times have no effect.

Optional Feature:
- Macro: CLA_PIPE_FLAGS_EN.
- Defined: adds outputs ovf (1 bit; signed overflow = carry into MSB XOR co) and zero (1 bit; s == 0).
  - Both registered with s, reset to 0, held during stall.
- Undefined: ports ovf and zero do not exist; no extra logic.

Decomposition:
- Shared package cla_pkg:
  - GRP_W = 4.
  - Function for ceil/derived group count.
  - Localparam for the subtract carry-in constant.
- Sub-module cla_group4: 4-bit a/b/cin → c1..c3, group G, group P.
  - Instantiated NGRP times, once in stage 1 for G/P and once in stage 2 for in-group carries.
- Group-level lookahead is generated inline in cla_pipe_adder.

Test Plan (WIDTH=32):
- Basic add: a=0x0000_0005, b=0x0000_0003, ci=1, sub=0, out_ready=1 → two cycles later s=0x0000_0009, co=0, out_valid for exactly one cycle.
- Full carry chain: a=0xFFFF_FFFF, b=0x0000_0000, ci=1 → s=0x0000_0000, co=1. With flags enabled: zero=1, ovf=0.
- Subtract with borrow: a=0x0000_0003, b=0x0000_0005, sub=1, ci=0 → s=0xFFFF_FFFE, co=0. Also a=0x8000_0000, b=1, sub=1 → s=0x7FFF_FFFF, co=1, ovf=1 with flags enabled.
- Backpressure: stream 4 back-to-back bundles (1+1, 2+2, 3+3, 4+4) with out_ready held 0 for 5 cycles.
  - in_ready drops after 2 accepted.
  - s holds 0x2 stable throughout.
  - On release, results 2, 4, 6, 8 emerge in order with no loss or duplication.
- Full throughput: in_valid=out_ready=1 for 100 random bundles → 100 results, each matching the reference sum, one per cycle after a 2-cycle fill.
- Reset mid-operation: assert reset with 2 bundles in flight → out_valid=0, s=0, co=0 immediately (asynchronously). After release, no stale result appears; the next bundle completes normally.
